// File: rtl/cfg_chain_loader_if.sv
// cfg_chain_loader_if
// Bundles the host write port, the serial chain pins and the status flags of
// cfg_chain_loader.
//   master : host/chain side. Drives START, VERIFY, WR_VALID, WR_DATA, CFG_Q.
//   slave  : loader side. Drives WR_READY, CFG_WE, CFG_D, BUSY, DONE, ERR, ERR_IDX.
// Parameter IDX_W sets the width of ERR_IDX and must match the loader's IDX_W.
interface cfg_chain_loader_if #(
  parameter int IDX_W = 9
);
  logic             START;
  logic             VERIFY;
  logic             WR_VALID;
  logic [15:0]      WR_DATA;
  logic             WR_READY;
  logic             CFG_WE;
  logic             CFG_D;
  logic             CFG_Q;
  logic             BUSY;
  logic             DONE;
  logic             ERR;
  logic [IDX_W-1:0] ERR_IDX;

  modport master (
    output START, VERIFY, WR_VALID, WR_DATA, CFG_Q,
    input  WR_READY, CFG_WE, CFG_D, BUSY, DONE, ERR, ERR_IDX
  );

  modport slave (
    input  START, VERIFY, WR_VALID, WR_DATA, CFG_Q,
    output WR_READY, CFG_WE, CFG_D, BUSY, DONE, ERR, ERR_IDX
  );
endinterface

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader
// Serial loader for the daisy-chained layer configuration registers. Host
// words (16 bit) are shifted into the chain LSB first over CFG_WE/CFG_D. With
// the optional verify pass the host re-sends the same words; the bits that
// come back on CFG_Q are compared against the bits being shifted in, and the
// first mismatching bit position is recorded.
// Ports:
//   CLK   : clock, rising edge
//   RSTB  : asynchronous active-low reset
//   bus   : cfg_chain_loader_if.slave
//           START/VERIFY (start a load, request verify), WR_VALID/WR_DATA/
//           WR_READY (host word handshake), CFG_WE/CFG_D (chain drive),
//           CFG_Q (chain return), BUSY, DONE, ERR, ERR_IDX (status)
// Parameters:
//   CHAIN_LEN : chain length in bits, multiple of 16
//   IDX_W     : ERR_IDX width, 2**IDX_W >= CHAIN_LEN
// Build option:
//   CFG_LOADER_VERIFY_EN : when defined, the verify pass (CHECK state, compare
//                          logic, ERR, ERR_IDX) is built; otherwise VERIFY is
//                          ignored and ERR/ERR_IDX read as 0.
module cfg_chain_loader #(
  parameter int CHAIN_LEN = 512,
  parameter int IDX_W     = 9
) (
  input  logic                CLK,
  input  logic                RSTB,
  cfg_chain_loader_if.slave   bus
);
  localparam int NWORDS = CHAIN_LEN / 16;
  localparam int WCNT_W = $clog2(NWORDS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_FIN} state_t;

  state_t              r_state;
  logic [15:0]         r_shift;
  logic [3:0]          r_bitcnt;   // position of the bit on CFG_D within its word
  logic [WCNT_W-1:0]   r_wcnt;     // words accepted in the current pass
  logic                r_cfg_we;   // shifter holds a bit being shifted this cycle
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [IDX_W-1:0]    r_err_idx;

  logic                w_active;
  logic                w_last_bit;
  logic                w_words_left;
  logic                w_ready;
  logic                w_accept;
  logic                w_pass_end;

  assign w_active     = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_last_bit   = r_cfg_we && (r_bitcnt == 4'd15);
  assign w_words_left = r_wcnt < WCNT_W'(NWORDS);
  // A new word may be taken when the shifter is empty, or when its last bit
  // leaves on this edge, which gives bubble-free back-to-back shifting.
  assign w_ready      = w_active && w_words_left && (!r_cfg_we || w_last_bit);
  assign w_accept     = w_ready && bus.WR_VALID;
  // Last bit of the last word of the pass is shifting on this edge.
  assign w_pass_end   = w_last_bit && !w_words_left;

`ifdef CFG_LOADER_VERIFY_EN
  logic                r_vreq;
  logic [WCNT_W-1:0]   w_word_idx;
  logic [IDX_W-1:0]    w_bit_idx;
  logic                w_mismatch;

  // The word on CFG_D is the most recently accepted one.
  assign w_word_idx = r_wcnt - WCNT_W'(1);
  assign w_bit_idx  = IDX_W'({w_word_idx, r_bitcnt});
  // CFG_Q is the bit that was shifted in at the same pass position during LOAD.
  assign w_mismatch = (r_state == S_CHECK) && r_cfg_we && (bus.CFG_Q != r_shift[0]);
`else
  logic w_unused;
  assign w_unused = ^{bus.VERIFY, bus.CFG_Q};
`endif

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state   <= S_IDLE;
      r_shift   <= 16'd0;
      r_bitcnt  <= 4'd0;
      r_wcnt    <= '0;
      r_cfg_we  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
`ifdef CFG_LOADER_VERIFY_EN
      r_vreq    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.START) begin
            r_state   <= S_LOAD;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
            r_err_idx <= '0;
            r_wcnt    <= '0;
            r_bitcnt  <= 4'd0;
`ifdef CFG_LOADER_VERIFY_EN
            r_vreq    <= bus.VERIFY;
`endif
          end
        end

        S_LOAD, S_CHECK: begin
          if (w_accept) begin
            r_shift  <= bus.WR_DATA;
            r_cfg_we <= 1'b1;
            r_bitcnt <= 4'd0;
            r_wcnt   <= r_wcnt + WCNT_W'(1);
          end else if (r_cfg_we) begin
            if (w_last_bit) begin
              // Shifter drained: keep its contents so CFG_D holds while stalled.
              r_cfg_we <= 1'b0;
            end else begin
              r_shift  <= {1'b0, r_shift[15:1]};
              r_bitcnt <= r_bitcnt + 4'd1;
            end
          end

`ifdef CFG_LOADER_VERIFY_EN
          if (w_mismatch && !r_err) begin
            r_err     <= 1'b1;
            r_err_idx <= w_bit_idx;
          end
`endif

          if (w_pass_end) begin
`ifdef CFG_LOADER_VERIFY_EN
            if ((r_state == S_LOAD) && r_vreq) begin
              r_state  <= S_CHECK;
              r_wcnt   <= '0;
              r_bitcnt <= 4'd0;
            end else begin
              r_state <= S_FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
`else
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.WR_READY = w_ready;
  assign bus.CFG_WE   = r_cfg_we;
  assign bus.CFG_D    = r_shift[0];
  assign bus.BUSY     = r_busy;
  assign bus.DONE     = r_done;
  assign bus.ERR      = r_err;
  assign bus.ERR_IDX  = r_err_idx;
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader
// Bench for cfg_chain_loader with CHAIN_LEN=32. A 32-bit shift-register model
// of the layer chain sits on CFG_WE/CFG_D/CFG_Q and can corrupt chosen bits
// right after the 32nd shift. Runs a table of directed vectors followed by
// randomized vectors whose expectations come from a pass-level model.
// Build option CFG_LOADER_VERIFY_EN selects the expectations for the build.
module tb_cfg_chain_loader;
  localparam int CL = 32;
  localparam int IW = 5;
`ifdef CFG_LOADER_VERIFY_EN
  localparam bit VEN = 1'b1;
`else
  localparam bit VEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  cfg_chain_loader_if #(.IDX_W(IW)) bus ();

  cfg_chain_loader #(.CHAIN_LEN(CL), .IDX_W(IW)) dut (
    .CLK  (clk),
    .RSTB (rstb),
    .bus  (bus.slave)
  );

  // Chain model: new bit enters at the top, CFG_Q is bit 0, so after a full
  // load bit p holds pass bit p.
  logic [CL-1:0] chain;
  logic [CL-1:0] flip_mask;
  logic          tb_clr;
  int unsigned   chain_shifts;

  assign bus.CFG_Q = chain[0];

  always @(posedge clk) begin
    if (tb_clr) begin
      chain_shifts <= 0;
    end else if (bus.CFG_WE) begin
      chain        <= {bus.CFG_D, chain[CL-1:1]} ^ ((chain_shifts == CL - 1) ? flip_mask : '0);
      chain_shifts <= chain_shifts + 1;
    end
  end

  typedef struct {
    bit            verify;
    logic [15:0]   w0;
    logic [15:0]   w1;
    int            d0, d1, d2, d3;   // stall cycles before each host send
    logic [CL-1:0] flip;
    int            start_mid;        // edge of an extra START pulse, -1 none
    int            rst_at;           // assert RSTB after this many shifts, -1 none
    logic [CL-1:0] exp_chain;
    bit            exp_err;
    logic [IW-1:0] exp_idx;
    int            exp_done;         // edge (START edge = 0) after which DONE is seen
    int            exp_we;           // cycles with CFG_WE high
    int            exp_gap;          // BUSY cycles with CFG_WE low
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  string cur_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h, expected %0h", cur_tag, name, act, exp);
    end
  endtask

  // Pass-level reference: one or two passes of CL bits, each costing CL+1
  // cycles from its start, plus every host stall cycle.
  function automatic void model(inout vec_t v);
    int passes;
    int stalls;
    passes = (v.verify && VEN) ? 2 : 1;
    stalls = v.d0 + v.d1 + ((passes == 2) ? (v.d2 + v.d3) : 0);
    v.exp_chain = {v.w1, v.w0} ^ ((passes == 1) ? v.flip : '0);
    v.exp_err   = (passes == 2) && (v.flip != '0);
    v.exp_idx   = '0;
    if (v.exp_err) begin
      for (int i = CL - 1; i >= 0; i--) begin
        if (v.flip[i]) v.exp_idx = IW'(i);
      end
    end
    v.exp_done = passes * (CL + 1) + stalls;
    v.exp_we   = passes * CL;
    v.exp_gap  = passes + stalls;
  endfunction

  task automatic run_vec(input vec_t v);
    int          e;
    int          done_e;
    int          we_n;
    int          gap_n;
    bit          fin;
    bit          pre_ready;
    bit          acc;
    int          wi;
    int          dl;
    int          total;
    logic [15:0] words [2];
    int          dly [4];

    words[0] = v.w0; words[1] = v.w1;
    dly[0] = v.d0; dly[1] = v.d1; dly[2] = v.d2; dly[3] = v.d3;
    total  = (v.verify && VEN) ? 4 : 2;
    e = -1; done_e = -1; we_n = 0; gap_n = 0; fin = 1'b0;
    wi = 0; dl = dly[0];

    flip_mask = v.flip;
    tb_clr    = 1'b1;
    @(posedge clk); #1;
    tb_clr    = 1'b0;

    bus.START    = 1'b1;
    bus.VERIFY   = v.verify;
    bus.WR_VALID = (dl == 0);
    bus.WR_DATA  = words[0];
    chk("idle_ready", bus.WR_READY, 1'b0);

    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      pre_ready = bus.WR_READY;
      acc       = bus.WR_VALID && pre_ready;
      @(posedge clk); #1;
      e++;
      bus.START = 1'b0;
      if (acc) begin
        wi++;
        dl = (wi < 4) ? dly[wi] : 0;
      end else if (pre_ready && dl > 0) begin
        dl--;
      end

      if (e == 0) begin
        chk("start_busy", bus.BUSY, 1'b1);
        chk("start_ready", bus.WR_READY, 1'b1);
      end
      if (e == v.start_mid) begin
        bus.START  = 1'b1;
        bus.VERIFY = ~v.verify;
      end
      if (bus.CFG_WE) we_n++;
      if (bus.BUSY && !bus.CFG_WE) gap_n++;

      if (v.rst_at >= 0 && we_n == v.rst_at) begin
        bus.WR_VALID = 1'b0;
        bus.START    = 1'b0;
        rstb = 1'b0;
        #1;
        chk("rst_we", bus.CFG_WE, 1'b0);
        chk("rst_busy", bus.BUSY, 1'b0);
        chk("rst_ready", bus.WR_READY, 1'b0);
        chk("rst_d", bus.CFG_D, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rstb = 1'b1;
        chk("rst_done", bus.DONE, 1'b0);
        $display("vec %s: reset after %0d shifts, we=%0d busy=%0d", cur_tag, we_n, bus.CFG_WE, bus.BUSY);
        return;
      end

      if (done_e >= 0) begin
        chk("done_width", bus.DONE, 1'b0);
        fin = 1'b1;
      end else if (bus.DONE) begin
        done_e = e;
        chk("done_busy", bus.BUSY, 1'b0);
      end

      if (wi < total) begin
        bus.WR_VALID = (dl == 0);
        bus.WR_DATA  = words[wi % 2];
      end else begin
        bus.WR_VALID = 1'b0;
        bus.WR_DATA  = 16'($urandom);
      end
    end

    bus.WR_VALID = 1'b0;
    if (done_e < 0) begin
      chk("done_timeout", 1'b0, 1'b1);
    end else begin
      chk("done_edge", done_e, v.exp_done);
    end
    chk("we_cycles", we_n, v.exp_we);
    chk("gap_cycles", gap_n, v.exp_gap);
    chk("chain", chain, v.exp_chain);
    chk("err", bus.ERR, v.exp_err);
    chk("err_idx", bus.ERR_IDX, v.exp_idx);
    $display("vec %s: verify=%0d words=%h,%h done@%0d we=%0d gap=%0d chain=%h err=%0d idx=%0d",
             cur_tag, v.verify, v.w0, v.w1, done_e, we_n, gap_n, chain, bus.ERR, bus.ERR_IDX);
  endtask

  vec_t tbl [7];
  vec_t rv;

  initial begin
    // Directed table; expectations written out by hand.
    tbl[0] = '{verify:0, w0:16'hA5C3, w1:16'h0F0F, d0:0, d1:0, d2:0, d3:0, flip:'0,
               start_mid:-1, rst_at:-1, exp_chain:32'h0F0FA5C3, exp_err:0, exp_idx:'0,
               exp_done:33, exp_we:32, exp_gap:1};
    tbl[1] = '{verify:0, w0:16'hA5C3, w1:16'h0F0F, d0:0, d1:5, d2:0, d3:0, flip:'0,
               start_mid:-1, rst_at:-1, exp_chain:32'h0F0FA5C3, exp_err:0, exp_idx:'0,
               exp_done:38, exp_we:32, exp_gap:6};
    tbl[2] = '{verify:1, w0:16'hA5C3, w1:16'h0F0F, d0:0, d1:0, d2:0, d3:0, flip:'0,
               start_mid:-1, rst_at:-1, exp_chain:32'h0F0FA5C3, exp_err:0, exp_idx:'0,
               exp_done:(VEN ? 66 : 33), exp_we:(VEN ? 64 : 32), exp_gap:(VEN ? 2 : 1)};
    tbl[3] = '{verify:1, w0:16'hA5C3, w1:16'h0F0F, d0:0, d1:0, d2:0, d3:0, flip:32'h0020_0000,
               start_mid:-1, rst_at:-1,
               exp_chain:(VEN ? 32'h0F0FA5C3 : 32'h0F2FA5C3), exp_err:VEN, exp_idx:(VEN ? 5'd21 : 5'd0),
               exp_done:(VEN ? 66 : 33), exp_we:(VEN ? 64 : 32), exp_gap:(VEN ? 2 : 1)};
    tbl[4] = '{verify:0, w0:16'h1234, w1:16'hFEDC, d0:0, d1:0, d2:0, d3:0, flip:'0,
               start_mid:10, rst_at:-1, exp_chain:32'hFEDC1234, exp_err:0, exp_idx:'0,
               exp_done:33, exp_we:32, exp_gap:1};
    tbl[5] = '{verify:0, w0:16'hA5C3, w1:16'h0F0F, d0:0, d1:0, d2:0, d3:0, flip:'0,
               start_mid:-1, rst_at:10, exp_chain:'0, exp_err:0, exp_idx:'0,
               exp_done:0, exp_we:0, exp_gap:0};
    tbl[6] = '{verify:1, w0:16'h8001, w1:16'h7FFE, d0:1, d1:0, d2:2, d3:1, flip:32'h4000_0008,
               start_mid:-1, rst_at:-1,
               exp_chain:(VEN ? 32'h7FFE8001 : 32'h3FFE8009), exp_err:VEN, exp_idx:(VEN ? 5'd3 : 5'd0),
               exp_done:(VEN ? 70 : 34), exp_we:(VEN ? 64 : 32), exp_gap:(VEN ? 6 : 2)};

    rstb         = 1'b0;
    tb_clr       = 1'b1;
    flip_mask    = '0;
    bus.START    = 1'b0;
    bus.VERIFY   = 1'b0;
    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = 16'hFFFF;
    cur_tag      = "reset";
    #3;
    chk("rst_ready", bus.WR_READY, 1'b0);
    chk("rst_we", bus.CFG_WE, 1'b0);
    chk("rst_d", bus.CFG_D, 1'b0);
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_done", bus.DONE, 1'b0);
    chk("rst_err", bus.ERR, 1'b0);
    chk("rst_idx", bus.ERR_IDX, '0);
    @(posedge clk); #1;
    rstb = 1'b1;
    @(posedge clk); #1;
    chk("idle_valid_ignored", bus.WR_READY, 1'b0);
    bus.WR_VALID = 1'b0;

    for (int i = 0; i < 7; i++) begin
      cur_tag = $sformatf("t%0d", i);
      run_vec(tbl[i]);
    end

    for (int i = 0; i < 20; i++) begin
      rv.verify    = 1'($urandom_range(0, 1));
      rv.w0        = 16'($urandom);
      rv.w1        = 16'($urandom);
      rv.d0        = $urandom_range(0, 3);
      rv.d1        = $urandom_range(0, 3);
      rv.d2        = $urandom_range(0, 3);
      rv.d3        = $urandom_range(0, 3);
      rv.flip      = '0;
      if ($urandom_range(0, 1) == 1) begin
        rv.flip[$urandom_range(0, CL - 1)] = 1'b1;
        rv.flip[$urandom_range(0, CL - 1)] = 1'b1;
      end
      rv.start_mid = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 25)) : -1;
      rv.rst_at    = -1;
      model(rv);
      cur_tag = $sformatf("r%0d", i);
      run_vec(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
